// File: rtl/flappy_pio_pkg.sv
// ---------------------------------------------------------------------------
// flappy_pio_pkg : shared register map and edge-type encoding for PIO blocks
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package flappy_pio_pkg;

   localparam logic [1:0] ADDR_DATA    = 2'd0;
   localparam logic [1:0] ADDR_RSVD    = 2'd1;
   localparam logic [1:0] ADDR_IRQMASK = 2'd2;
   localparam logic [1:0] ADDR_EDGECAP = 2'd3;

   typedef enum logic [1:0] {
      EDGE_RISE = 2'd0,
      EDGE_FALL = 2'd1,
      EDGE_ANY  = 2'd2
   } edge_type_e;

endpackage

`default_nettype wire

// File: rtl/pio_debounce.sv
// ---------------------------------------------------------------------------
// pio_debounce : one-bit 2-flop synchronizer followed by a stable-count filter
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pio_debounce
   import flappy_pio_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic din,
   output logic level
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1;
   logic             sync2;
   logic             data;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         data  <= 1'b0;
         cnt   <= '0;
      end else begin
         sync1 <= din;
         sync2 <= sync1;
         // Any stable cycle restarts the count, so a glitch never accumulates.
         if (sync2 == data) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            data <= sync2;
            cnt  <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   assign level = data;

endmodule

`default_nettype wire

// File: rtl/flappy_keys_pio.sv
// ---------------------------------------------------------------------------
// flappy_keys_pio : debounced push-button input PIO with edge capture and IRQ
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module flappy_keys_pio
   import flappy_pio_pkg::*;
#(
   parameter int WIDTH           = 4,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int EDGE_TYPE       = 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic             irq
);

   localparam edge_type_e EDGE_SEL = edge_type_e'(EDGE_TYPE);

   logic [WIDTH-1:0] data;
   logic [WIDTH-1:0] data_d;
   logic [WIDTH-1:0] edge_evt;
   logic [WIDTH-1:0] irq_mask;
   logic [WIDTH-1:0] edge_cap;
   logic [WIDTH-1:0] cap_clr;
   logic             wr_en;
   logic             unused_wdata;

   generate
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
         pio_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
         ) u_debounce (
            .clk     (clk),
            .reset_n (reset_n),
            .din     (in_port[i]),
            .level   (data[i])
         );
      end
   endgenerate

   always_comb begin
      edge_evt = '0;
      case (EDGE_SEL)
         EDGE_RISE: edge_evt = data & ~data_d;
         EDGE_FALL: edge_evt = ~data & data_d;
         EDGE_ANY:  edge_evt = data ^ data_d;
         default:   edge_evt = '0;
      endcase
   end

   assign wr_en   = chipselect & ~write_n;
   assign cap_clr = (wr_en && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;

   // Upper write-data bits have no storage behind them.
   assign unused_wdata = &{1'b0, writedata};

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         data_d   <= '0;
         irq_mask <= '0;
         edge_cap <= '0;
         irq      <= 1'b0;
      end else begin
         data_d <= data;
         if (wr_en && address == ADDR_IRQMASK) begin
            irq_mask <= writedata[WIDTH-1:0];
         end
         // A new edge wins over a simultaneous write-one-to-clear.
         edge_cap <= edge_evt | (edge_cap & ~cap_clr);
         irq      <= |(edge_cap & irq_mask);
      end
   end

   always_comb begin
      readdata = '0;
      case (address)
         ADDR_DATA:    readdata[WIDTH-1:0] = data;
         ADDR_IRQMASK: readdata[WIDTH-1:0] = irq_mask;
         ADDR_EDGECAP: readdata[WIDTH-1:0] = edge_cap;
         default:      readdata = '0;
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_flappy_keys_pio.sv
// ---------------------------------------------------------------------------
// tb_flappy_keys_pio : directed self-checking bench for flappy_keys_pio
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_flappy_keys_pio;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [3:0]  in_port;
   logic        irq;

   int total = 0;
   int bad   = 0;

   flappy_keys_pio #(
      .WIDTH           (4),
      .DEBOUNCE_CYCLES (4),
      .EDGE_TYPE       (1)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .in_port    (in_port),
      .irq        (irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] d);
      address    = a;
      chipselect = 1'b1;
      write_n    = 1'b1;
      #1;
      d = readdata;
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      @(posedge clk);
      #1;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
   endtask

   logic [31:0] v;

   initial begin
      reset_n    = 1'b0;
      in_port    = 4'hF;
      address    = 2'd0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;

      // Reset held three cycles
      step(3);
      for (int a = 0; a < 4; a++) begin
         rd(2'(a), v);
         check($sformatf("reset_rd%0d", a), v, 32'h0);
      end
      check("reset_irq", {31'b0, irq}, 32'h0);

      // Idle-high buttons reach DATA at cycle 2+D after release
      reset_n = 1'b1;
      step(5);
      rd(2'd0, v); check("data_cyc5", v, 32'h0);
      step(1);
      rd(2'd0, v); check("data_cyc6", v, 32'hF);
      step(2);
      rd(2'd3, v); check("edgecap_after_rise", v, 32'h0);

      // Three-cycle glitch is rejected
      in_port = 4'hE;
      step(3);
      in_port = 4'hF;
      step(10);
      rd(2'd0, v); check("glitch_data", v, 32'hF);
      rd(2'd3, v); check("glitch_edgecap", v, 32'h0);

      // Valid press on bit 0 with mask 1
      wr(2'd2, 32'h1);
      rd(2'd2, v); check("irqmask_rd", v, 32'h1);
      in_port = 4'hE;
      step(5);
      rd(2'd0, v); check("press_data_early", v, 32'hF);
      step(1);
      rd(2'd0, v); check("press_data", v, 32'hE);
      rd(2'd3, v); check("press_edgecap_early", v, 32'h0);
      step(1);
      rd(2'd3, v); check("press_edgecap", v, 32'h1);
      check("press_irq_early", {31'b0, irq}, 32'h0);
      step(1);
      check("press_irq", {31'b0, irq}, 32'h1);

      // Clear: zero write is a no-op, one-write clears
      wr(2'd3, 32'h0);
      rd(2'd3, v); check("w1c_zero", v, 32'h1);
      wr(2'd3, 32'h1);
      rd(2'd3, v); check("w1c_clear", v, 32'h0);
      check("w1c_irq_lag", {31'b0, irq}, 32'h1);
      step(1);
      check("w1c_irq_off", {31'b0, irq}, 32'h0);

      // Clear collides with a new edge on bit 1
      in_port = 4'hC;
      step(6);
      rd(2'd0, v); check("bit1_data", v, 32'hC);
      wr(2'd3, 32'h2);
      rd(2'd3, v); check("edge_beats_clear", v, 32'h2);
      check("bit1_irq_masked", {31'b0, irq}, 32'h0);
      wr(2'd3, 32'h2);
      rd(2'd3, v); check("bit1_cleared", v, 32'h0);

      // Edge on bit 2 masked, then unmasked
      in_port = 4'h8;
      step(6);
      rd(2'd0, v); check("bit2_data", v, 32'h8);
      step(1);
      rd(2'd3, v); check("bit2_edgecap", v, 32'h4);
      step(2);
      check("bit2_irq_masked", {31'b0, irq}, 32'h0);
      wr(2'd2, 32'h4);
      check("mask_irq_lag", {31'b0, irq}, 32'h0);
      step(1);
      check("mask_irq_on", {31'b0, irq}, 32'h1);
      rd(2'd2, v); check("mask_rd", v, 32'h4);

      // Reserved address and read-only DATA
      wr(2'd1, 32'hFFFF_FFFF);
      rd(2'd1, v); check("rsvd_rd", v, 32'h0);
      wr(2'd0, 32'h0000_0005);
      rd(2'd0, v); check("data_ro", v, 32'h8);

      // Release: rising edges are not captured in falling mode
      in_port = 4'hF;
      step(8);
      rd(2'd0, v); check("release_data", v, 32'hF);
      rd(2'd3, v); check("release_edgecap", v, 32'h4);

      // Reset mid-debounce wipes everything
      in_port = 4'hE;
      step(3);
      reset_n = 1'b0;
      step(1);
      rd(2'd0, v); check("midrst_data", v, 32'h0);
      rd(2'd2, v); check("midrst_mask", v, 32'h0);
      rd(2'd3, v); check("midrst_edgecap", v, 32'h0);
      check("midrst_irq", {31'b0, irq}, 32'h0);
      in_port = 4'hF;
      reset_n = 1'b1;
      step(6);
      rd(2'd0, v); check("postrst_data", v, 32'hF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/flappy_keys_pio.md
# flappy_keys_pio

Memory-mapped input PIO on the FlappyBird SoC Avalon bus. It samples the board push-buttons, which are asynchronous and bouncy, and synchronizes and debounces each bit. It detects edges into a sticky edge-capture register and raises a level interrupt to the Nios II for the game's flap/start controls. It is the read-side counterpart of the LED output PIO and uses the same 2-bit-address, zero-wait-state slave style.

## Interface
- WIDTH, 4 — number of input bits.
- DEBOUNCE_CYCLES, 500000 — consecutive stable cycles required to accept a new level (10 ms at 50 MHz); must be ≥1.
- EDGE_TYPE, 1 — 0 = rising, 1 = falling, 2 = any edge.
- clk  in  1  system clock.
- reset_n  in  1  reset, synchronous, active-low.
- address  in  2  register select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  read data, combinational, zero-extended.
- in_port  in  WIDTH  raw asynchronous button inputs.
- irq  out  1  level interrupt.

## Operation
- One clock and one reset. Reset is synchronous and active-low: clk and reset_n are sampled on the rising edge of clk.
- Input path per bit:
  - 2-flop synchronizer, then a debouncer, then the filtered level `data`.
  - Debouncer behaviour: while the synced value ≠ `data`, increment the counter; when the counter reaches DEBOUNCE_CYCLES−1, load `data` from the synced value and clear the counter. Any cycle where synced == `data` clears the counter.
  - Counter width is $clog2(DEBOUNCE_CYCLES+1). There is no wrap: the counter never exceeds DEBOUNCE_CYCLES−1.
- Edge detect: register `data_d` = `data` delayed one cycle.
  - rise = data & ~data_d; fall = ~data & data_d; the bit selected by EDGE_TYPE drives `edge_evt`.
- Register map, read data zero-extended to 32 bits:
  - 0 DATA (RO): `data`. Writes are ignored.
  - 1 reserved: reads 0, writes ignored.
  - 2 IRQMASK (RW): `irq_mask[WIDTH-1:0]`.
  - 3 EDGECAP (R/W1C): `edge_cap`. Writing 1 to a bit clears that bit.
- Writes happen when chipselect && ~write_n. Reads are combinational on address and have no side effects.
- edge_cap[i]: the next value is 1 if edge_evt[i]. Otherwise it is 0 if a W1C write hits with writedata[i]=1. Otherwise it holds. A new edge therefore beats a simultaneous clear.
- irq = |(edge_cap & irq_mask), registered.

## Timing
- Reset values: sync flops, `data`, and `data_d` reset to 0. Debounce counters, irq_mask, edge_cap, and irq reset to 0. readdata reflects these reset values.
- Default levels and first-edge behaviour after reset:
  - Buttons idle high; `data` reaches 1 after 2 + DEBOUNCE_CYCLES cycles.
  - That 0→1 transition produces a rising edge. With EDGE_TYPE=0 or 2 it sets edge_cap, and software clears it at init.
- Latency from an in_port change held stable:
  - `data` updates 2 (sync) + DEBOUNCE_CYCLES cycles after the change.
  - edge_cap sets 1 cycle after that.
  - irq asserts 1 cycle after that.
- Glitches shorter than DEBOUNCE_CYCLES after synchronization are rejected entirely, with no change to `data` or edge_cap.
- A W1C write clears edge_cap at the next edge; irq deasserts one cycle later.
- An IRQMASK write takes effect on irq one cycle after the register updates.
- Reset asserted mid-debounce or mid-capture returns every register to its reset value on the next clk edge. No partial state survives.

## Structure
- Shared package `flappy_pio_pkg`:
  - address constants ADDR_DATA=0, ADDR_IRQMASK=2, ADDR_EDGECAP=3;
  - edge-type enum EDGE_RISE/EDGE_FALL/EDGE_ANY.
- Sub-module `pio_debounce` (one bit): the synchronizer plus the counter. The top instantiates WIDTH copies in a generate loop.
- The top holds data_d, edge detect, the register file, the read mux, and irq.

## Test plan
- Reset: hold reset_n=0 for 3 cycles with in_port=4'hF → readdata=0 at all addresses and irq=0. After release, with DEBOUNCE_CYCLES=4 and EDGE_TYPE=1, DATA=4'hF at cycle 6.
- Debounce rejection: pulse in_port[0] low for 3 cycles (DEBOUNCE_CYCLES=4) → DATA stays 4'hF and EDGECAP stays 0.
- Valid press: in_port[0] low and held, IRQMASK=4'h1 → DATA=4'hE after 6 cycles, EDGECAP=4'h1 one cycle later, irq=1 one cycle after that.
- Clear: write EDGECAP with 32'h1 → EDGECAP=0, then irq=0 on the following cycle. Writing 32'h0 leaves EDGECAP unchanged.
- Simultaneous events: issue a W1C on bit 1 in the same cycle as edge_evt[1] → EDGECAP[1] stays 1.
- Masking: with an edge on bit 2 and IRQMASK=4'h1 → irq=0. Then write IRQMASK=4'h4 → irq=1 two cycles after the write. Address 1 reads 0, and a write to DATA has no effect.
